level_ctrl: RTL and testbench

- Game-level sequencer that sits directly upstream of the ball motion block, on frame_clk (one tick per video frame).
- Drives startx/starty, goalx/goaly and a ball reset into the ball block, and consumes the ball's success flag.
- Runs the title → play → win/lose flow, keeps the per-level frame/second timer, and publishes the current level index to the maze map ROM.

---
 rtl/level_pkg.sv | 31 +++
 rtl/level_ctrl_key_edge.sv | 32 +++
 rtl/level_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_level_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared types and constants for the level sequencer: FSM state encoding,
// key codes and the per-level start/goal tile table.
package level_pkg;

  typedef enum logic [2:0] {
    ST_TITLE = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef logic [4:0] tile_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;

  localparam int MAX_LEVELS = 8;

  // Slots beyond the four designed levels repeat L0 so the table is always full.
  localparam tile_t START_X [MAX_LEVELS] = '{5'd6,  5'd2,  5'd2,  5'd16, 5'd6,  5'd6,  5'd6,  5'd6};
  localparam tile_t START_Y [MAX_LEVELS] = '{5'd6,  5'd2,  5'd18, 5'd2,  5'd6,  5'd6,  5'd6,  5'd6};
  localparam tile_t GOAL_X  [MAX_LEVELS] = '{5'd26, 5'd28, 5'd28, 5'd16, 5'd26, 5'd26, 5'd26, 5'd26};
  localparam tile_t GOAL_Y  [MAX_LEVELS] = '{5'd20, 5'd2,  5'd18, 5'd26, 5'd20, 5'd20, 5'd20, 5'd20};

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/level_ctrl_key_edge.sv
// Scans the eight HID key bytes for one key code and emits a one-frame
// pulse when that key goes from released to pressed.
module key_edge
  import level_pkg::*;
#(
  parameter logic [7:0] KEY_CODE = KEY_ENTER
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [63:0] keycode,
  output logic        key_rise
);

  logic hit;
  logic prev_d, prev_q;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (keycode[i*8 +: 8] == KEY_CODE) hit = 1'b1;
    end
    prev_d   = hit;
    key_rise = hit & ~prev_q;
  end

  // Reset to "pressed" so a key held through Reset is not seen as a new press.
  always_ff @(posedge frame_clk) begin
    if (Reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

endmodule

// File: rtl/level_ctrl.sv
// Game-level sequencer: title/play/win/lose flow, per-level timer and the
// start/goal tiles handed to the ball block.
//
// state | meaning
// TITLE | waiting for Enter to begin at level 0
// LOAD  | one frame: latch level tiles, clear timer
// PLAY  | ball released, timer running
// WIN   | goal reached, holding before next level
// LOSE  | time ran out, Enter retries, Esc quits
// DONE  | all levels cleared, Enter returns to title
module level_ctrl
  import level_pkg::*;
#(
  parameter int NUM_LEVELS     = 4,
  parameter int FRAMES_PER_SEC = 60,
  parameter int TIME_LIMIT     = 99,
  parameter int WIN_HOLD       = 120
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [63:0] keycode,
  input  logic        success,
  output logic        ball_reset,
  output logic [2:0]  level,
  output logic [4:0]  startx,
  output logic [4:0]  starty,
  output logic [4:0]  goalx,
  output logic [4:0]  goaly,
  output logic [6:0]  time_sec,
  output logic [2:0]  state_o,
  output logic        game_done
);

  localparam int FC_W = cnt_width(FRAMES_PER_SEC);
  localparam int HC_W = cnt_width(WIN_HOLD);

  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAMES_PER_SEC - 1);
  localparam logic [HC_W-1:0] HC_LAST   = HC_W'(WIN_HOLD - 1);
  localparam logic [6:0]      T_LIMIT   = 7'(TIME_LIMIT);
  localparam logic [2:0]      LVL_LAST  = 3'(NUM_LEVELS - 1);
  localparam logic [3:0]      LVL_COUNT = 4'(NUM_LEVELS);

  logic enter_rise, esc_rise;

  key_edge #(.KEY_CODE(KEY_ENTER)) u_enter (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .key_rise  (enter_rise)
  );

  key_edge #(.KEY_CODE(KEY_ESC)) u_esc (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .key_rise  (esc_rise)
  );

  state_e          state_d, state_q;
  logic [2:0]      level_d, level_q;
  logic [FC_W-1:0] frame_cnt_d, frame_cnt_q;
  logic [HC_W-1:0] hold_cnt_d, hold_cnt_q;
  logic [6:0]      time_sec_d, time_sec_q;
  tile_t           startx_d, startx_q, starty_d, starty_q;
  tile_t           goalx_d, goalx_q, goaly_d, goaly_q;
  logic            ball_reset_d, ball_reset_q;
  logic            game_done_d, game_done_q;
  logic [2:0]      tbl_idx;

  // Out-of-range level indices fall back to the first table entry.
  assign tbl_idx = ({1'b0, level_q} < LVL_COUNT) ? level_q : 3'd0;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    time_sec_d  = time_sec_q;
    startx_d    = startx_q;
    starty_d    = starty_q;
    goalx_d     = goalx_q;
    goaly_d     = goaly_q;

    case (state_q)
      ST_TITLE: begin
        if (enter_rise) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        startx_d    = START_X[tbl_idx];
        starty_d    = START_Y[tbl_idx];
        goalx_d     = GOAL_X[tbl_idx];
        goaly_d     = GOAL_Y[tbl_idx];
        frame_cnt_d = '0;
        time_sec_d  = '0;
        state_d     = ST_PLAY;
      end

      ST_PLAY: begin
        if (esc_rise) begin
          state_d = ST_TITLE;
          level_d = '0;
        end else if (success) begin
          state_d    = ST_WIN;
          hold_cnt_d = '0;
        end else if (time_sec_q == T_LIMIT) begin
          state_d = ST_LOSE;
        end else if (frame_cnt_q == FC_LAST) begin
          frame_cnt_d = '0;
          if (time_sec_q < T_LIMIT) time_sec_d = time_sec_q + 7'd1;
        end else begin
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
      end

      ST_WIN: begin
        if (hold_cnt_q == HC_LAST) begin
          if (level_q == LVL_LAST) begin
            state_d = ST_DONE;
          end else begin
            level_d = level_q + 3'd1;
            state_d = ST_LOAD;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end

      ST_LOSE: begin
        if (esc_rise) begin
          state_d = ST_TITLE;
          level_d = '0;
        end else if (enter_rise) begin
          state_d = ST_LOAD;
        end
      end

      ST_DONE: begin
        if (enter_rise) begin
          state_d = ST_TITLE;
          level_d = '0;
        end
      end

      default: begin
        state_d = ST_TITLE;
        level_d = '0;
      end
    endcase

    // Registered from next state so they line up with state_o.
    ball_reset_d = (state_d != ST_PLAY);
    game_done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= ST_TITLE;
      level_q      <= '0;
      frame_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      time_sec_q   <= '0;
      startx_q     <= START_X[0];
      starty_q     <= START_Y[0];
      goalx_q      <= GOAL_X[0];
      goaly_q      <= GOAL_Y[0];
      ball_reset_q <= 1'b1;
      game_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      frame_cnt_q  <= frame_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      time_sec_q   <= time_sec_d;
      startx_q     <= startx_d;
      starty_q     <= starty_d;
      goalx_q      <= goalx_d;
      goaly_q      <= goaly_d;
      ball_reset_q <= ball_reset_d;
      game_done_q  <= game_done_d;
    end
  end

  assign ball_reset = ball_reset_q;
  assign level      = level_q;
  assign startx     = startx_q;
  assign starty     = starty_q;
  assign goalx      = goalx_q;
  assign goaly      = goaly_q;
  assign time_sec   = time_sec_q;
  assign state_o    = state_q;
  assign game_done  = game_done_q;

endmodule

// File: tb/tb_level_ctrl.sv
// Scoreboard bench for level_ctrl: a game-level reference model pushes the
// expected outputs per frame, a monitor pops and compares after each edge.
module tb_level_ctrl;

  localparam int NL  = 4;
  localparam int FPS = 4;
  localparam int TL  = 3;
  localparam int WH  = 6;

  localparam int S_TITLE = 0, S_LOAD = 1, S_PLAY = 2, S_WIN = 3, S_LOSE = 4, S_DONE = 5;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] lvl;
    logic       br;
    logic [4:0] sx;
    logic [4:0] sy;
    logic [4:0] gx;
    logic [4:0] gy;
    logic [6:0] ts;
    logic       gd;
  } obs_t;

  logic        frame_clk;
  logic        Reset;
  logic [63:0] keycode;
  logic        success;
  logic        ball_reset;
  logic [2:0]  level;
  logic [4:0]  startx, starty, goalx, goaly;
  logic [6:0]  time_sec;
  logic [2:0]  state_o;
  logic        game_done;

  level_ctrl #(
    .NUM_LEVELS     (NL),
    .FRAMES_PER_SEC (FPS),
    .TIME_LIMIT     (TL),
    .WIN_HOLD       (WH)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .success    (success),
    .ball_reset (ball_reset),
    .level      (level),
    .startx     (startx),
    .starty     (starty),
    .goalx      (goalx),
    .goaly      (goaly),
    .time_sec   (time_sec),
    .state_o    (state_o),
    .game_done  (game_done)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Reference level table, straight from the level list.
  int tbl_sx [NL] = '{6, 2, 2, 16};
  int tbl_sy [NL] = '{6, 2, 18, 2};
  int tbl_gx [NL] = '{26, 28, 28, 16};
  int tbl_gy [NL] = '{20, 2, 18, 26};

  // Model: game position plus frames played/frames won, time derived by division.
  int m_st, m_lvl, m_play, m_win;
  int m_sx, m_sy, m_gx, m_gy;
  bit m_prev_ent, m_prev_esc;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   frame_no = 0;
  bit   stim_done = 0;

  task automatic go_title();
    m_st  = S_TITLE;
    m_lvl = 0;
  endtask

  task automatic model_step(input logic [63:0] kc, input bit succ, input bit rst);
    bit en, es, er, sr;
    int secs;
    en = 0;
    es = 0;
    for (int i = 0; i < 8; i++) begin
      if (kc[i*8 +: 8] == 8'h28) en = 1;
      if (kc[i*8 +: 8] == 8'h29) es = 1;
    end
    if (rst) begin
      go_title();
      m_play = 0; m_win = 0;
      m_sx = tbl_sx[0]; m_sy = tbl_sy[0]; m_gx = tbl_gx[0]; m_gy = tbl_gy[0];
      m_prev_ent = 1; m_prev_esc = 1;
      return;
    end
    er = en && !m_prev_ent;
    sr = es && !m_prev_esc;
    m_prev_ent = en;
    m_prev_esc = es;
    secs = m_play / FPS;
    case (m_st)
      S_TITLE: if (er) m_st = S_LOAD;
      S_LOAD: begin
        m_sx = tbl_sx[m_lvl]; m_sy = tbl_sy[m_lvl];
        m_gx = tbl_gx[m_lvl]; m_gy = tbl_gy[m_lvl];
        m_play = 0;
        m_st = S_PLAY;
      end
      S_PLAY: begin
        if (sr) go_title();
        else if (succ) begin m_st = S_WIN; m_win = 0; end
        else if (secs >= TL) m_st = S_LOSE;
        else m_play++;
      end
      S_WIN: begin
        m_win++;
        if (m_win == WH) begin
          if (m_lvl == NL - 1) m_st = S_DONE;
          else begin m_lvl++; m_st = S_LOAD; end
        end
      end
      S_LOSE: begin
        if (sr) go_title();
        else if (er) m_st = S_LOAD;
      end
      S_DONE: if (er) go_title();
      default: go_title();
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    int secs;
    secs = m_play / FPS;
    if (secs > TL) secs = TL;
    o.st  = 3'(m_st);
    o.lvl = 3'(m_lvl);
    o.br  = (m_st != S_PLAY);
    o.sx  = 5'(m_sx);
    o.sy  = 5'(m_sy);
    o.gx  = 5'(m_gx);
    o.gy  = 5'(m_gy);
    o.ts  = 7'(secs);
    o.gd  = (m_st == S_DONE);
    return o;
  endfunction

  // mode: 0 none, 1 Enter, 2 Esc; noise bytes never hit either code.
  function automatic logic [63:0] make_kc(input int mode, input int pos);
    logic [63:0] k;
    for (int i = 0; i < 8; i++)
      k[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(8'h2A, 8'hFF));
    if (mode == 1) k[pos*8 +: 8] = 8'h28;
    if (mode == 2) k[pos*8 +: 8] = 8'h29;
    return k;
  endfunction

  task automatic frame(input logic [63:0] kc, input bit succ, input bit rst);
    keycode = kc;
    success = succ;
    Reset   = rst;
    model_step(kc, succ, rst);
    exp_q.push_back(model_obs());
    @(negedge frame_clk);
  endtask

  task automatic frames(input int n, input int mode, input bit succ);
    for (int i = 0; i < n; i++) frame(make_kc(mode, int'($urandom_range(0, 7))), succ, 1'b0);
  endtask

  initial begin : driver
    int mode, pos;
    // Reset, then Enter in byte 3 for two frames.
    frame(64'd0, 1'b0, 1'b1);
    frame(64'd0, 1'b0, 1'b1);
    frames(3, 0, 1'b0);
    frame(make_kc(1, 3), 1'b0, 1'b0);
    frame(make_kc(1, 3), 1'b0, 1'b0);
    // Play a few seconds, win level 0, hold through WIN into level 1.
    frames(9, 0, 1'b0);
    frames(1, 0, 1'b1);
    frames(WH + 2, 0, 1'b0);
    // Time out on level 1, idle in LOSE, retry.
    frames(TL * FPS + 3, 0, 1'b0);
    frames(1, 0, 1'b0);
    frames(1, 1, 1'b0);
    frames(3, 0, 1'b0);
    // Clear levels 1..3 to reach DONE, then Enter back to title.
    for (int l = 1; l < NL; l++) begin
      frames(1, 0, 1'b1);
      frames(WH + 2, 0, 1'b0);
    end
    frames(2, 0, 1'b0);
    frames(1, 1, 1'b0);
    frames(2, 0, 1'b0);
    // Esc and success together in PLAY.
    frames(1, 1, 1'b0);
    frames(3, 0, 1'b0);
    frames(1, 2, 1'b1);
    frames(2, 0, 1'b0);
    // Enter held straight through Reset.
    frames(3, 1, 1'b0);
    frame(make_kc(1, 5), 1'b0, 1'b1);
    frame(make_kc(1, 5), 1'b0, 1'b1);
    frames(4, 1, 1'b0);
    frames(2, 0, 1'b0);
    frames(2, 1, 1'b0);
    // Reset in the middle of WIN.
    frames(2, 0, 1'b0);
    frames(1, 0, 1'b1);
    frames(3, 0, 1'b0);
    frame(64'd0, 1'b0, 1'b1);
    frames(3, 0, 1'b0);
    // Random play.
    mode = 0;
    pos  = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        r    = int'($urandom_range(0, 99));
        mode = (r < 50) ? 0 : (r < 85) ? 1 : 2;
        pos  = int'($urandom_range(0, 7));
      end
      frame(make_kc(mode, pos), ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
    end
    stim_done = 1;
  end

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{state_o, level, ball_reset, startx, starty, goalx, goaly, time_sec, game_done};
        frame_no++;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL frame_obs #%0d: got st=%0d lvl=%0d br=%0d s=(%0d,%0d) g=(%0d,%0d) t=%0d done=%0d | want st=%0d lvl=%0d br=%0d s=(%0d,%0d) g=(%0d,%0d) t=%0d done=%0d",
                   frame_no, a.st, a.lvl, a.br, a.sx, a.sy, a.gx, a.gy, a.ts, a.gd,
                   e.st, e.lvl, e.br, e.sx, e.sy, e.gx, e.gy, e.ts, e.gd);
        end
      end
    end
  end

  initial begin : finisher
    wait (stim_done);
    repeat (4) @(posedge frame_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want stimulus complete");
    $fatal(1, "watchdog");
  end

endmodule
